// File: rtl/m_mem_mux_arb_if.sv
// m_mem_mux_arb_if
//   Bundles the two requester channels and the memory-side outputs of the
//   Slipstream address-path arbiter.
//   Requester side : REQ1/ADDR1/WR1 (CPU), REQ2/ADDR2/WR2/HOLD2 (blitter)
//   Memory side    : SEL, MADDR, MWR, MSTB, ACK1, ACK2, BUSY
//   slave  modport : the arbiter (consumes requests, drives memory side)
//   master modport : the requesters / environment
interface m_mem_mux_arb_if #(
    parameter int unsigned AW = 20
);
    logic          REQ1;
    logic [AW-1:0] ADDR1;
    logic          WR1;
    logic          REQ2;
    logic [AW-1:0] ADDR2;
    logic          WR2;
    logic          HOLD2;
    logic          SEL;
    logic [AW-1:0] MADDR;
    logic          MWR;
    logic          MSTB;
    logic          ACK1;
    logic          ACK2;
    logic          BUSY;

    modport slave (
        input  REQ1, ADDR1, WR1, REQ2, ADDR2, WR2, HOLD2,
        output SEL, MADDR, MWR, MSTB, ACK1, ACK2, BUSY
    );

    modport master (
        output REQ1, ADDR1, WR1, REQ2, ADDR2, WR2, HOLD2,
        input  SEL, MADDR, MWR, MSTB, ACK1, ACK2, BUSY
    );
endinterface

// File: rtl/m_mem_mux_arb.sv
// m_mem_mux_arb
//   Arbitrates the shared memory address path between the CPU (mux IN1,
//   SEL=0) and the blitter (mux IN2, SEL=1). Grants are made only in IDLE;
//   a one-cycle TURN is inserted whenever SEL must change so the TMUX1 bank
//   never switches under a strobe. Each access holds MSTB for WAITS+1
//   cycles and ends with a one-cycle ACK to the owning requester.
//   Ports:
//     CLK   - system clock, rising edge
//     RESET - synchronous active-high reset
//     bus   - slave modport: requests in, SEL/MADDR/MWR/MSTB/ACKn/BUSY out
//   Parameters: AW address width, WAITS wait states (0..7),
//               MAXHOLD max blitter hold grants while CPU waits (1..15)
module m_mem_mux_arb #(
    parameter int unsigned AW      = 20,
    parameter int unsigned WAITS   = 2,
    parameter int unsigned MAXHOLD = 4
) (
    input  logic           CLK,
    input  logic           RESET,
    m_mem_mux_arb_if.slave bus
);

    localparam logic [2:0] WAITS_C   = 3'(WAITS);
    localparam logic [3:0] MAXHOLD_C = 4'(MAXHOLD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic          mwr_q, mwr_d;
    logic          mstb_q, mstb_d;
    logic          ack1_q, ack1_d;
    logic          ack2_q, ack2_d;
    logic          busy_q, busy_d;
    logic          last2_q, last2_d;   // 1 when the blitter had the last grant
    logic [3:0]    hold_q, hold_d;
    logic [2:0]    wcnt_q, wcnt_d;
    logic          win2;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            maddr_q <= '0;
            mwr_q   <= 1'b0;
            mstb_q  <= 1'b0;
            ack1_q  <= 1'b0;
            ack2_q  <= 1'b0;
            busy_q  <= 1'b0;
            last2_q <= 1'b1;
            hold_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            maddr_q <= maddr_d;
            mwr_q   <= mwr_d;
            mstb_q  <= mstb_d;
            ack1_q  <= ack1_d;
            ack2_q  <= ack2_d;
            busy_q  <= busy_d;
            last2_q <= last2_d;
            hold_q  <= hold_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        maddr_d = maddr_q;
        mwr_d   = mwr_q;
        mstb_d  = 1'b0;
        ack1_d  = 1'b0;
        ack2_d  = 1'b0;
        busy_d  = 1'b0;
        last2_d = last2_q;
        hold_d  = hold_q;
        wcnt_d  = wcnt_q;

        // Tie: blitter keeps the bus under HOLD2 until the hold budget is
        // spent, otherwise plain round robin.
        if (bus.REQ1 && bus.REQ2) begin
            if (last2_q && bus.HOLD2 && (hold_q < MAXHOLD_C))
                win2 = 1'b1;
            else
                win2 = ~last2_q;
        end else begin
            win2 = bus.REQ2;
        end

        // ACK outputs are registered, so each is raised on the edge that
        // enters the final strobe cycle (count will equal WAITS there).
        unique case (state_q)
            IDLE: begin
                if (bus.REQ1 || bus.REQ2) begin
                    maddr_d = win2 ? bus.ADDR2 : bus.ADDR1;
                    mwr_d   = win2 ? bus.WR2 : bus.WR1;
                    last2_d = win2;
                    hold_d  = (win2 && bus.REQ1 && bus.HOLD2) ? hold_q + 4'd1 : 4'd0;
                    wcnt_d  = '0;
                    busy_d  = 1'b1;
                    if (win2 == sel_q) begin
                        state_d = ACCESS;
                        mstb_d  = 1'b1;
                        ack1_d  = (WAITS_C == 3'd0) && !win2;
                        ack2_d  = (WAITS_C == 3'd0) && win2;
                    end else begin
                        state_d = TURN;
                        sel_d   = win2;
                    end
                end
            end
            TURN: begin
                state_d = ACCESS;
                mstb_d  = 1'b1;
                busy_d  = 1'b1;
                wcnt_d  = '0;
                ack1_d  = (WAITS_C == 3'd0) && !sel_q;
                ack2_d  = (WAITS_C == 3'd0) && sel_q;
            end
            ACCESS: begin
                if (wcnt_q == WAITS_C) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d  = wcnt_q + 3'd1;
                    mstb_d  = 1'b1;
                    busy_d  = 1'b1;
                    ack1_d  = ((wcnt_q + 3'd1) == WAITS_C) && !sel_q;
                    ack2_d  = ((wcnt_q + 3'd1) == WAITS_C) && sel_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.SEL   = sel_q;
    assign bus.MADDR = maddr_q;
    assign bus.MWR   = mwr_q;
    assign bus.MSTB  = mstb_q;
    assign bus.ACK1  = ack1_q;
    assign bus.ACK2  = ack2_q;
    assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_m_mem_mux_arb.sv
// tb_m_mem_mux_arb
//   Directed bench for m_mem_mux_arb with WAITS=2, MAXHOLD=4. Inputs are
//   driven and outputs sampled on the falling edge; "cycle k" is the
//   interval after the k-th rising edge following stimulus setup.
//   Status vector order: {SEL, MSTB, ACK1, ACK2, BUSY}.
module tb_m_mem_mux_arb;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    m_mem_mux_arb_if #(.AW(20)) bus ();

    m_mem_mux_arb #(
        .AW      (20),
        .WAITS   (2),
        .MAXHOLD (4)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [4:0] exp);
        @(negedge clk);
        check(tag, 32'({bus.SEL, bus.MSTB, bus.ACK1, bus.ACK2, bus.BUSY}), 32'(exp));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step("reset", 5'b00000);
        check("reset_maddr", 32'(bus.MADDR), 32'h0);
        rst = 1'b0;
    endtask

    // Both ACKs may never be high together.
    always @(negedge clk)
        if (!rst && bus.ACK1 && bus.ACK2)
            check("ack_excl", 32'({bus.ACK1, bus.ACK2}), 32'h0);

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.REQ1  = 1'b0;
        bus.ADDR1 = '0;
        bus.WR1   = 1'b0;
        bus.REQ2  = 1'b0;
        bus.ADDR2 = '0;
        bus.WR2   = 1'b0;
        bus.HOLD2 = 1'b0;

        // Reset and idle
        step("rst_a", 5'b00000);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("idle", 5'b00000);
            check("idle_maddr", 32'(bus.MADDR), 32'h0);
        end

        // Single CPU write; ADDR1/WR1 changes mid-access are ignored
        bus.REQ1 = 1'b1; bus.ADDR1 = 20'h12345; bus.WR1 = 1'b1;
        step("cpu_c1", 5'b01001);
        check("cpu_maddr", 32'(bus.MADDR), 32'h12345);
        check("cpu_mwr", 32'(bus.MWR), 32'h1);
        bus.ADDR1 = 20'hFFFFF; bus.WR1 = 1'b0;
        step("cpu_c2", 5'b01001);
        step("cpu_c3", 5'b01101);
        bus.REQ1 = 1'b0;
        step("cpu_c4", 5'b00000);
        check("cpu_maddr_keep", 32'(bus.MADDR), 32'h12345);
        check("cpu_mwr_keep", 32'(bus.MWR), 32'h1);

        // Tie after reset: CPU first, then blitter via TURN
        pulse_reset();
        bus.REQ1 = 1'b1; bus.ADDR1 = 20'h0A0A0; bus.WR1 = 1'b0;
        bus.REQ2 = 1'b1; bus.ADDR2 = 20'hB0B0B; bus.WR2 = 1'b1;
        step("tie_c1", 5'b01001);
        check("tie_maddr1", 32'(bus.MADDR), 32'h0A0A0);
        step("tie_c2", 5'b01001);
        step("tie_c3", 5'b01101);
        bus.REQ1 = 1'b0;
        step("tie_c4", 5'b00000);
        step("tie_c5_turn", 5'b10001);
        step("tie_c6", 5'b11001);
        check("tie_maddr2", 32'(bus.MADDR), 32'hB0B0B);
        check("tie_mwr2", 32'(bus.MWR), 32'h1);
        step("tie_c7", 5'b11001);
        step("tie_c8", 5'b11011);
        bus.REQ2 = 1'b0;
        step("tie_c9", 5'b10000);

        // Hold fairness: one blitter grant, then REQ1 joins; 4 more blitter grants
        pulse_reset();
        bus.REQ2 = 1'b1; bus.HOLD2 = 1'b1; bus.ADDR2 = 20'h22222;
        step("hold_turn", 5'b10001);
        step("hold_a1", 5'b11001);
        step("hold_a2", 5'b11001);
        step("hold_a3", 5'b11011);
        bus.REQ1 = 1'b1; bus.ADDR1 = 20'h11111;
        for (int i = 0; i < 4; i++) begin
            step("hold_idle", 5'b10000);
            step("hold_b1", 5'b11001);
            check("hold_maddr", 32'(bus.MADDR), 32'h22222);
            step("hold_b2", 5'b11001);
            step("hold_b3", 5'b11011);
        end
        step("hold_idle_end", 5'b10000);
        step("hold_cpu_turn", 5'b00001);
        step("hold_cpu1", 5'b01001);
        check("hold_cpu_maddr", 32'(bus.MADDR), 32'h11111);
        step("hold_cpu2", 5'b01001);
        step("hold_cpu3", 5'b01101);
        bus.REQ1 = 1'b0; bus.REQ2 = 1'b0; bus.HOLD2 = 1'b0;
        step("hold_done", 5'b00000);

        // Blitter drops REQ2 in the second strobe cycle
        bus.REQ2 = 1'b1; bus.ADDR2 = 20'h55555;
        step("drop_turn", 5'b10001);
        step("drop_a1", 5'b11001);
        step("drop_a2", 5'b11001);
        bus.REQ2 = 1'b0;
        step("drop_a3", 5'b11011);
        step("drop_idle1", 5'b10000);
        step("drop_idle2", 5'b10000);

        // Reset in the second strobe of a same-side blitter access
        bus.REQ2 = 1'b1; bus.ADDR2 = 20'h0AAAA;
        step("rmid_a1", 5'b11001);
        step("rmid_a2", 5'b11001);
        rst = 1'b1; bus.REQ2 = 1'b0; bus.REQ1 = 1'b1; bus.ADDR1 = 20'h00777;
        step("rmid_reset", 5'b00000);
        check("rmid_maddr", 32'(bus.MADDR), 32'h0);
        rst = 1'b0;
        step("rmid_cpu1", 5'b01001);
        check("rmid_cpu_maddr", 32'(bus.MADDR), 32'h00777);
        step("rmid_cpu2", 5'b01001);
        step("rmid_cpu3", 5'b01101);
        bus.REQ1 = 1'b0;
        step("rmid_idle", 5'b00000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/m_mem_mux_arb.md
# m_mem_mux_arb

Two-requester arbiter and sequencer for the shared Slipstream memory address path, built from TMUX1 2:1 mux cells. It decides which requester owns the path: requester 1 (CPU) on the IN1 side, requester 2 (blitter) on the IN2 side. It drives the mux SEL, registers the winning address and write flag, and times a fixed-length memory access with a strobe and a per-requester acknowledge. A dead turnaround cycle is inserted whenever SEL must change, so the mux never switches during a strobe.

## Interface
Parameters:
- AW, 20: address width.
- WAITS, 2: wait states; each access has MSTB high for WAITS+1 cycles. Legal range 0..7.
- MAXHOLD, 4: maximum consecutive grants to requester 2 under HOLD2 while REQ1 is pending. Legal range 1..15.

Ports:
- CLK  in  1  system clock; everything is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ1  in  1  CPU access request; level, held until ACK1.
- ADDR1  in  AW  CPU address.
- WR1  in  1  CPU write flag (1=write).
- REQ2  in  1  blitter access request; level, held until ACK2.
- ADDR2  in  AW  blitter address.
- WR2  in  1  blitter write flag.
- HOLD2  in  1  blitter asks to keep the bus across back-to-back accesses.
- SEL  out  1  mux select to the TMUX1 bank; 0=IN1/CPU, 1=IN2/blitter.
- MADDR  out  AW  registered access address.
- MWR  out  1  registered write flag.
- MSTB  out  1  memory access strobe.
- ACK1  out  1  one-cycle pulse marking completion of a CPU access.
- ACK2  out  1  one-cycle pulse marking completion of a blitter access.
- BUSY  out  1  high in TURN and ACCESS.

## Operation
- States: IDLE, TURN, ACCESS.
- Reset state: IDLE. SEL=0, MADDR=0, MWR=0, MSTB=0, ACK1=ACK2=0, BUSY=0. Last-grant = 2, so the CPU wins the first tie. Hold counter = 0. Wait counter = 0.
- Arbitration happens only in IDLE, on REQ1/REQ2 as sampled at the clock edge:
  - Only one request: that side wins.
  - Both requests, default: the side not last granted wins (round robin).
  - Both requests, hold override: if last-grant=2, HOLD2=1 and hold counter < MAXHOLD, requester 2 wins.
- Grant actions:
  - Latch winner's address into MADDR and write flag into MWR.
  - Update last-grant.
  - Hold counter increments on a grant to 2 while REQ1=1 and HOLD2=1; otherwise it clears to 0.
- Transitions:
  - IDLE → ACCESS when winner equals current SEL.
  - IDLE → TURN when winner differs; SEL toggles at that edge.
  - TURN → ACCESS unconditionally, after 1 cycle.
- ACCESS:
  - MSTB=1 and the wait counter runs 0..WAITS.
  - In the cycle with count==WAITS, ACKn for the owning side is 1.
  - Next state is IDLE.
- SEL, MADDR and MWR are constant from TURN/ACCESS entry until the next grant. Input changes on ADDRn/WRn during an access are ignored.
- A requester that drops REQ mid-access does not abort the access: it completes and ACK still pulses.
- REQn still high in the IDLE cycle after ACKn counts as a new request.
- RESET during TURN or ACCESS aborts immediately to the reset state with no ACK. A pending request is re-arbitrated after reset.
- ACK1 and ACK2 are never high in the same cycle. MSTB is never high in IDLE or TURN.

## Timing
- All outputs are registered; none are combinational from inputs.
- Same-side access with a request sampled in IDLE cycle n:
  - MSTB high in cycles n+1 .. n+1+WAITS.
  - ACK in cycle n+1+WAITS.
  - IDLE again at n+2+WAITS.
- Side switch: TURN at n+1 with the new SEL and MSTB=0. MSTB high n+2 .. n+2+WAITS. ACK at n+2+WAITS.
- Back-to-back same-side throughput: one access per WAITS+2 cycles.
- Minimum gap between MSTB bursts: one IDLE cycle.

## Test plan
- Reset and idle:
  - Stimulus: assert RESET, then release with no requests.
  - Required: SEL=0, MSTB=0, BUSY=0, ACK1=ACK2=0, MADDR=0, held indefinitely.
- Single CPU access, WAITS=2:
  - Stimulus: REQ1=1, ADDR1=0x12345, WR1=1, sampled in cycle 0.
  - Required: MSTB high in cycles 1-3, MADDR=0x12345, MWR=1, SEL=0, ACK1 only in cycle 3, IDLE in cycle 4.
- Tie after reset:
  - Stimulus: REQ1 and REQ2 rise together in cycle 0, both held.
  - Required:
    - CPU is granted first (MSTB cycles 1-3, ACK1 in cycle 3).
    - Blitter request is sampled in IDLE cycle 4; SEL=1 from cycle 5 (TURN).
    - Blitter MSTB in cycles 6-8, ACK2 in cycle 8.
- Hold fairness, MAXHOLD=4:
  - Stimulus: REQ1, REQ2 and HOLD2 held high after one blitter grant.
  - Required: exactly 4 consecutive blitter accesses, then the CPU is granted with a TURN cycle (SEL 1→0, MSTB=0).
- Request dropped mid-access:
  - Stimulus: REQ2 deasserted in the second MSTB cycle.
  - Required: MSTB remains for all WAITS+1 cycles, ACK2 pulses, next state is IDLE.
- Reset mid-access:
  - Stimulus: RESET asserted in the second MSTB cycle of a blitter access.
  - Required: next cycle MSTB=0, ACK2=0, SEL=0, BUSY=0. After release with REQ1 held, the CPU is granted with no TURN.
